// File: rtl/hazard_stall_controller.sv
// Stall/flush controller beside the ID stage of the 5-stage pipeline.
// Load-use stalls (multi-cycle), branch flush, dmem wait freeze, stall counter.
//
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   instr_IFID           IF/ID instruction (rs=[25:21], rt=[20:16])
//   uses_rs/rt_IFID      IF/ID source-read qualifiers
//   MemRead_IDEX         ID/EX holds a load
//   dest_IDEX            load destination in ID/EX
//   branch_taken_EX      taken branch/jump resolved in EX
//   dmem_req/dmem_ready  MEM-stage access and completion
//   PCWrite, Write_IFID  PC / IF/ID load enables
//   set_HDU              bubble into ID/EX
//   flush_IFID/IDEX      squash wrong-path instructions
//   stall_all            freeze ID/EX, EX/MEM, MEM/WB
//   stall_count          saturating count of PCWrite=0 cycles
module hazard_stall_controller #(
   parameter int BIT_WIDTH       = 32,
   parameter int REG_ADDR_W      = 5,
   parameter int LOAD_USE_CYCLES = 1,
   parameter int COUNT_W         = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [BIT_WIDTH-1:0]  instr_IFID,
   input  logic                  uses_rs_IFID,
   input  logic                  uses_rt_IFID,
   input  logic                  MemRead_IDEX,
   input  logic [REG_ADDR_W-1:0] dest_IDEX,
   input  logic                  branch_taken_EX,
   input  logic                  dmem_req,
   input  logic                  dmem_ready,
   output logic                  PCWrite,
   output logic                  Write_IFID,
   output logic                  set_HDU,
   output logic                  flush_IFID,
   output logic                  flush_IDEX,
   output logic                  stall_all,
   output logic [COUNT_W-1:0]    stall_count
);

   typedef enum logic [1:0] {
      IDLE,
      LU_STALL,
      MEM_WAIT
   } state_t;

   localparam logic [2:0] LU_INIT = 3'(LOAD_USE_CYCLES - 1);

   state_t              r_state;
   state_t              w_state_nxt;
   logic [2:0]          r_cnt;
   logic [2:0]          w_cnt_nxt;
   logic [COUNT_W-1:0]  r_count;

   logic [REG_ADDR_W-1:0] w_rs;
   logic [REG_ADDR_W-1:0] w_rt;
   logic                  w_hazard;
   logic                  w_memwait;
   logic                  w_in_lu;
   logic                  w_unused;

   assign w_rs = instr_IFID[25:21];
   assign w_rt = instr_IFID[20:16];
   assign w_unused = ^{instr_IFID[BIT_WIDTH-1:26], instr_IFID[15:0]};

   assign w_hazard = MemRead_IDEX
                   & (dest_IDEX != '0)
                   & ((uses_rs_IFID & (w_rs == dest_IDEX))
                    | (uses_rt_IFID & (w_rt == dest_IDEX)));

   assign w_memwait = dmem_req & ~dmem_ready;

   // A nonzero cnt in MEM_WAIT is the frozen load-use context to resume.
   assign w_in_lu = (r_state == LU_STALL)
                  | ((r_state == MEM_WAIT) & (r_cnt != 3'd0));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_cnt   <= 3'd0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_comb begin
      PCWrite     = 1'b1;
      Write_IFID  = 1'b1;
      set_HDU     = 1'b0;
      flush_IFID  = 1'b0;
      flush_IDEX  = 1'b0;
      stall_all   = 1'b0;
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      priority case (1'b1)
         !rst_n: begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = 3'd0;
         end
         w_memwait: begin
            stall_all   = 1'b1;
            PCWrite     = 1'b0;
            Write_IFID  = 1'b0;
            w_state_nxt = MEM_WAIT;
         end
         branch_taken_EX: begin
            flush_IFID  = 1'b1;
            flush_IDEX  = 1'b1;
            w_state_nxt = IDLE;
            w_cnt_nxt   = 3'd0;
         end
         // ID/EX holds a bubble here, so MemRead_IDEX is ignored.
         w_in_lu: begin
            PCWrite    = 1'b0;
            Write_IFID = 1'b0;
            set_HDU    = 1'b1;
            if (r_cnt == 3'd1) begin
               w_state_nxt = IDLE;
               w_cnt_nxt   = 3'd0;
            end else begin
               w_state_nxt = LU_STALL;
               w_cnt_nxt   = r_cnt - 3'd1;
            end
         end
         default: begin
            w_state_nxt = IDLE;
            if (w_hazard) begin
               PCWrite    = 1'b0;
               Write_IFID = 1'b0;
               set_HDU    = 1'b1;
               if (LOAD_USE_CYCLES > 1) begin
                  w_state_nxt = LU_STALL;
                  w_cnt_nxt   = LU_INIT;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (!PCWrite && (r_count != '1)) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign stall_count = r_count;

endmodule
